// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants and operation type for the operand stack
package stack_pkg;

    localparam int STACK_WIDTH = 32;
    localparam int STACK_DEPTH = 16;
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1);

    // Encoding is {push, pop} so the decode is a plain cast.
    typedef enum logic [1:0] {
        NOP     = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - unreset storage array, one sync write port, two comb read ports
module stack_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage carries no reset; entries above the stack pointer are never exposed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - LIFO operand stack with zero-latency TOS/NOS and sticky errors
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clear_err,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    sp_q, sp_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [CW-1:0]    sp_m1, sp_m2;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    stack_op_e        op;

    assign sp_m1 = sp_q - CW'(1);
    assign sp_m2 = sp_q - CW'(2);
    assign empty = (sp_q == '0);
    assign full  = (sp_q == CW'(DEPTH));
    assign op    = decode_op(push, pop);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (din),
        .raddr_a (sp_m1[AW-1:0]),
        .rdata_a (rdata_a),
        .raddr_b (sp_m2[AW-1:0]),
        .rdata_b (rdata_b)
    );

    // Next stack pointer, write strobe and sticky flags; an error event beats clear_err.
    always_comb begin
        sp_d        = sp_q;
        we          = 1'b0;
        waddr       = sp_q[AW-1:0];
        overflow_d  = overflow_q & ~clear_err;
        underflow_d = underflow_q & ~clear_err;
        case (op)
            PUSH: begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + CW'(1);
                end
            end
            POP: begin
                if (empty) begin
                    underflow_d = 1'b1;
                end else begin
                    sp_d = sp_m1;
                end
            end
            REPLACE: begin
                if (empty) begin
                    underflow_d = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = sp_m1[AW-1:0];
                end
            end
            default: begin
            end
        endcase
    end

    // Stack pointer and error flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Mask stale storage so invalid positions read as zero.
    assign tos       = empty ? '0 : rdata_a;
    assign nos       = (sp_q >= CW'(2)) ? rdata_b : '0;
    assign count     = sp_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - scoreboard bench for operand_stack
module tb_operand_stack;

    localparam int W = 32;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] din = '0;
    logic         clear_err = 1'b0;
    logic [W-1:0] tos, nos;
    logic [4:0]   count;
    logic         empty, full, overflow, underflow;

    operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .clear_err (clear_err),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] tos;
        logic [31:0] nos;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vid = 0;
    event async_chk;

    task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Monitor: after each edge (or an async reset probe) pop one expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_chk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                cmp(e.id, "tos", tos, e.tos);
                cmp(e.id, "nos", nos, e.nos);
                cmp(e.id, "count", 32'(count), 32'(e.cnt));
                cmp(e.id, "empty", 32'(empty), 32'(e.cnt == 0));
                cmp(e.id, "full", 32'(full), 32'(e.cnt == D));
                cmp(e.id, "overflow", 32'(overflow), 32'(e.ovf));
                cmp(e.id, "underflow", 32'(underflow), 32'(e.unf));
            end
        end
    end

    task automatic expect_state(input logic [31:0] t, input logic [31:0] n, input int c,
                                input logic ov, input logic un);
        exp_t e;
        e.id  = vid;
        e.tos = t;
        e.nos = n;
        e.cnt = c;
        e.ovf = ov;
        e.unf = un;
        vid++;
        sb.push_back(e);
    endtask

    // Drive one operation for the next edge and queue the state expected after it.
    task automatic apply(input logic p, input logic q, input logic [31:0] d, input logic c,
                         input logic [31:0] t, input logic [31:0] n, input int cnt,
                         input logic ov, input logic un);
        @(posedge clk);
        #2;
        push      = p;
        pop       = q;
        din       = d;
        clear_err = c;
        expect_state(t, n, cnt, ov, un);
    endtask

    initial begin
        // Reset held from time zero: probe outputs without any clock edge.
        #1;
        expect_state(0, 0, 0, 0, 0);
        -> async_chk;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // idle after reset
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // three pushes, three pops
        apply(1, 0, 32'h11, 0, 32'h11, 0, 1, 0, 0);
        apply(1, 0, 32'h22, 0, 32'h22, 32'h11, 2, 0, 0);
        apply(1, 0, 32'h33, 0, 32'h33, 32'h22, 3, 0, 0);
        apply(0, 1, 0, 0, 32'h22, 32'h11, 2, 0, 0);
        apply(0, 1, 0, 0, 32'h11, 0, 1, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // fill to DEPTH with 1..16
        for (int i = 1; i <= D; i++) begin
            apply(1, 0, 32'(i), 0, 32'(i), (i >= 2) ? 32'(i - 1) : 32'h0, i, 0, 0);
        end
        apply(1, 0, 32'hFF, 0, 32'd16, 32'd15, 16, 1, 0);   // push while full
        apply(1, 1, 32'hAA, 0, 32'hAA, 32'd15, 16, 1, 0);   // replace while full
        apply(0, 0, 0, 1, 32'hAA, 32'd15, 16, 0, 0);        // clear alone
        apply(1, 0, 32'hEE, 1, 32'hAA, 32'd15, 16, 1, 0);   // overflow beats clear
        apply(0, 0, 0, 1, 32'hAA, 32'd15, 16, 0, 0);

        // drain: mem[k-1] holds k for k<=15
        for (int c = 15; c >= 0; c--) begin
            apply(0, 1, 0, 0, (c > 0) ? 32'(c) : 32'h0, (c >= 2) ? 32'(c - 1) : 32'h0, c, 0, 0);
        end

        // underflow cases
        apply(0, 1, 0, 0, 0, 0, 0, 0, 1);                   // pop empty
        apply(1, 1, 32'h99, 0, 0, 0, 0, 0, 1);              // replace empty
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);                   // clear alone
        apply(0, 1, 0, 1, 0, 0, 0, 0, 1);                   // underflow beats clear
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // five entries then replace
        for (int i = 1; i <= 5; i++) begin
            apply(1, 0, 32'h50 + 32'(i), 0, 32'h50 + 32'(i), (i >= 2) ? 32'h4F + 32'(i) : 32'h0, i, 0, 0);
        end
        apply(1, 1, 32'h77, 0, 32'h77, 32'h54, 5, 0, 0);

        // three more pushes, then async reset between edges
        apply(1, 0, 32'h61, 0, 32'h61, 32'h77, 6, 0, 0);
        apply(1, 0, 32'h62, 0, 32'h62, 32'h61, 7, 0, 0);
        apply(1, 0, 32'h63, 0, 32'h63, 32'h62, 8, 0, 0);
        @(posedge clk);
        #2;
        push = 1'b0;
        pop  = 1'b0;
        clear_err = 1'b0;
        reset_n = 1'b0;
        expect_state(0, 0, 0, 0, 0);
        -> async_chk;
        #3;
        reset_n = 1'b1;
        apply(1, 0, 32'h5, 0, 32'h5, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 32'h5, 0, 1, 0, 0);

        @(posedge clk);
        #2;
        push = 1'b0;
        pop  = 1'b0;
        clear_err = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(posedge clk);
            #3;
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
